pwm_duty_ctrl: RTL and testbench
================================

# pwm_duty_ctrl

Programmable square-wave / PWM controller that generates a waveform of configurable period and high time, counted in clock cycles. It sequences the waveform counter, accepts new period/duty settings through a valid/ready handshake, and applies them only at period boundaries so the output never shows a truncated or glitched cycle. It is the synthesizable replacement for free-running delay-based duty-cycle generators and drives waveform outputs in the team's clock/waveform benches and designs.

## Interface
- CNT_W, 8, width of the period/high counters
- DEF_PERIOD, 40, period loaded at reset (cycles)
- DEF_HIGH, 16, high time loaded at reset (cycles; 40% duty)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run request (level)
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  controller can accept a configuration
- cfg_period  in  CNT_W  requested period in cycles
- cfg_high  in  CNT_W  requested high time in cycles
- cfg_err  out  1  one-cycle pulse: accepted config had period 0, discarded
- wave  out  1  generated waveform
- period_start  out  1  one-cycle pulse on first cycle of each period
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, RUN, STOP. IDLE: cnt=0, wave=0. RUN: cnt counts 0..act_period-1, wraps to 0. STOP: finishes current period, then IDLE.
- IDLE->RUN when en=1 and act_period!=0. RUN->STOP when en=0. STOP->RUN when en=1 (no gap, cnt continues). STOP->IDLE on wrap (cnt==act_period-1).
- wave=1 iff cnt >= act_period - eff_high, eff_high = min(act_high, act_period). Low phase first, high phase last (phase 0 = period start, low).
- act_high=0: wave stays 0. act_high>=act_period: wave stays 1 in RUN/STOP.
- Config: one shadow slot. cfg_ready = !pending. Handshake = cfg_valid & cfg_ready. cfg_period=0: discarded, cfg_err pulses next cycle, slot stays empty.
- Pending applied: in IDLE on the next edge; in RUN/STOP at wrap, so the new period starts with cnt=0 and new values.
- Simultaneous en and handshake in IDLE: config lands first; the run starts one cycle later using new values.
- Reset: state=IDLE, cnt=0, act_period=DEF_PERIOD, act_high=DEF_HIGH, pending=0, wave=0, period_start=0, cfg_err=0, busy=0, cfg_ready=1.
- Reset mid-period: all outputs to reset values immediately (asynchronous); pending config lost.
- Counter arithmetic unsigned CNT_W bits; comparison width CNT_W, no overflow (cnt < act_period <= 2^CNT_W-1).

## Timing
- en sampled high in IDLE at edge N: RUN from edge N+1, cnt=0, period_start=1 in that cycle.
- wave, period_start, cfg_err, busy are registered outputs. wave is valid in the same cycle as the cnt it is computed from.
- Period exactly act_period cycles; high time exactly eff_high cycles; no idle cycle between periods.
- act_period=1: period_start high every cycle.
- Handshake at edge N: cfg_ready=0 from N+1 until the cycle after application.

## Structure
- Package pwm_pkg: state enum (IDLE, RUN, STOP), default period/high constants.
- Sub-module pwm_cfg_shadow: shadow registers, pending flag, cfg_ready/cfg_err handshake, load strobe input from the main FSM.
- Top holds FSM, counter, compare and output registers.

## Test plan
- Reset defaults, en=1: period_start every 40 cycles; wave low 24, high 16; busy=1.
- In RUN, cfg 10/5 at cnt=7: current 40-cycle period completes unchanged; next period 10 cycles, high 5; cfg_ready low until applied.
- cfg_period=0: cfg_err pulses once, settings unchanged, cfg_ready stays 1.
- cfg_high=0 -> wave constantly 0; cfg_high=50 with period 40 -> wave constantly 1.
- en dropped at cnt=5 of 40: period finishes, IDLE at wrap, wave=0; en reasserted at cnt=20 -> RUN with no gap.
- rst_n asserted mid-high-phase: wave, busy, period_start go 0 immediately; after release, defaults 40/16 active.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and reset defaults for the PWM duty-cycle controller.
// The controller FSM states are exported so benches can observe them directly.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W      = 8;
  localparam int unsigned PWM_DEF_PERIOD = 40;
  localparam int unsigned PWM_DEF_HIGH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_cfg_shadow.sv
// One-slot shadow register for period/high settings with a valid/ready intake.
// The main FSM decides when the slot is consumed by pulsing load.
module pwm_cfg_shadow #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             load,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             cfg_accept,
  output logic             pending,
  output logic [CNT_W-1:0] sh_period,
  output logic [CNT_W-1:0] sh_high
);

  // Handshake: a transfer happens on a rising edge where cfg_valid and
  // cfg_ready are both high; ready depends only on the slot being empty.
  logic             hs;
  logic             pending_q, pending_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] sh_period_q, sh_period_d;
  logic [CNT_W-1:0] sh_high_q, sh_high_d;

  always_comb begin
    hs          = cfg_valid & ~pending_q;
    cfg_accept  = hs & (cfg_period != '0);
    pending_d   = pending_q;
    sh_period_d = sh_period_q;
    sh_high_d   = sh_high_q;
    err_d       = hs & (cfg_period == '0);
    if (load) begin
      pending_d = 1'b0;
    end
    // load only fires while the slot is full, so it never races an accept
    if (cfg_accept) begin
      pending_d   = 1'b1;
      sh_period_d = cfg_period;
      sh_high_d   = cfg_high;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
      sh_period_q <= '0;
      sh_high_q   <= '0;
    end else begin
      pending_q   <= pending_d;
      err_q       <= err_d;
      sh_period_q <= sh_period_d;
      sh_high_q   <= sh_high_d;
    end
  end

  assign cfg_ready = ~pending_q;
  assign cfg_err   = err_q;
  assign pending   = pending_q;
  assign sh_period = sh_period_q;
  assign sh_high   = sh_high_q;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// PWM generator: low phase then high phase per period, settings swapped only
// at period boundaries (or immediately while idle).
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W      = PWM_CNT_W,
  parameter int unsigned DEF_PERIOD = PWM_DEF_PERIOD,
  parameter int unsigned DEF_HIGH   = PWM_DEF_HIGH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_err,
  output logic             wave,
  output logic             period_start,
  output logic             busy,
  output pwm_state_e       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_high_q, act_high_d;
  logic             wave_q, wave_d;
  logic             period_start_q, period_start_d;
  logic             busy_q, busy_d;

  logic             load;
  logic             wrap;
  logic             cfg_accept;
  logic             pending;
  logic [CNT_W-1:0] sh_period;
  logic [CNT_W-1:0] sh_high;
  logic [CNT_W-1:0] eff_high;

  pwm_cfg_shadow #(
    .CNT_W (CNT_W)
  ) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .load       (load),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .cfg_accept (cfg_accept),
    .pending    (pending),
    .sh_period  (sh_period),
    .sh_high    (sh_high)
  );

  // Settings in force for the cycle after the edge; the shadow slot is
  // consumed immediately while idle and only at wrap while running.
  always_comb begin
    wrap         = (cnt_q == (act_period_q - CNT_ONE));
    load         = pending & ((state_q == ST_IDLE) | wrap);
    act_period_d = load ? sh_period : act_period_q;
    act_high_d   = load ? sh_high : act_high_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // a config arriving together with en lands first; the run waits a cycle
        if (en && !cfg_accept && (act_period_d != '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = wrap ? '0 : (cnt_q + CNT_ONE);
        if (!en) begin
          state_d = wrap ? ST_IDLE : ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_d = wrap ? '0 : (cnt_q + CNT_ONE);
        if (en) begin
          state_d = ST_RUN;
        end else if (wrap) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (state_d == ST_IDLE) begin
      cnt_d = '0;
    end
  end

  // Outputs are registered but computed from next-cycle count and settings,
  // so wave lines up with the cnt value it belongs to.
  always_comb begin
    eff_high       = (act_high_d > act_period_d) ? act_period_d : act_high_d;
    busy_d         = (state_d != ST_IDLE);
    wave_d         = busy_d && (cnt_d >= (act_period_d - eff_high));
    period_start_d = busy_d && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      act_period_q   <= CNT_W'(DEF_PERIOD);
      act_high_q     <= CNT_W'(DEF_HIGH);
      wave_q         <= 1'b0;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      act_period_q   <= act_period_d;
      act_high_q     <= act_high_d;
      wave_q         <= wave_d;
      period_start_q <= period_start_d;
      busy_q         <= busy_d;
    end
  end

  assign wave         = wave_q;
  assign period_start = period_start_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Self-checking bench for pwm_duty_ctrl: per-cycle {period_start, wave, busy}
// expectations are queued from the scenario and compared as the DUT runs.
module tb_pwm_duty_ctrl;
  import pwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_period;
  logic [7:0] cfg_high;
  logic       cfg_err;
  logic       wave;
  logic       period_start;
  logic       busy;
  pwm_state_e dbg_state;

  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_v;
  logic [2:0] got;

  pwm_duty_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_high     (cfg_high),
    .cfg_err      (cfg_err),
    .wave         (wave),
    .period_start (period_start),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // expected {period_start, wave, busy} for one full period
  task automatic push_period(input int p, input int h);
    int eh;
    eh = (h > p) ? p : h;
    for (int i = 0; i < p; i++) begin
      exp_q.push_back({(i == 0), (i >= p - eh), 1'b1});
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(3'b000);
  endtask

  task automatic drive_cfg(input logic v, input int p, input int h);
    cfg_valid  = v;
    cfg_period = 8'(p);
    cfg_high   = 8'(h);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    drive_cfg(1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({period_start, wave, busy, cfg_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outs: got ps/wave/busy/err=%b want 0000", {period_start, wave, busy, cfg_err});
    end
    n_vec++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 1", cfg_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0 || wave !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got state=%0d busy=%b wave=%b want 0/0/0", dbg_state, busy, wave);
    end
  endtask

  task automatic test_defaults();
    int n;
    en = 1'b1;
    push_period(40, 16);
    push_period(40, 16);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      got   = {period_start, wave, busy};
      exp_v = exp_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL defaults cyc %0d: got ps/wave/busy=%b want %b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_cfg_change();
    int n;
    push_period(40, 16);
    push_period(10, 5);
    push_period(10, 5);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      got   = {period_start, wave, busy};
      exp_v = exp_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL cfg_change cyc %0d: got ps/wave/busy=%b want %b", i, got, exp_v);
      end
      if (i >= 8 && i <= 40) begin
        n_vec++;
        if (cfg_ready !== (i == 40)) begin
          n_err++;
          $display("FAIL cfg_change_ready cyc %0d: got %b want %b", i, cfg_ready, (i == 40));
        end
      end
      if (i == 7) drive_cfg(1'b1, 10, 5);
      if (i == 8) drive_cfg(1'b0, 0, 0);
    end
  endtask

  task automatic test_cfg_zero();
    int n;
    push_period(10, 5);
    push_period(10, 5);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      got   = {period_start, wave, busy};
      exp_v = exp_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL cfg_zero cyc %0d: got ps/wave/busy=%b want %b", i, got, exp_v);
      end
      n_vec++;
      if (cfg_err !== (i == 1) || cfg_ready !== 1'b1) begin
        n_err++;
        $display("FAIL cfg_zero_err cyc %0d: got err/ready=%b%b want %b1", i, cfg_err, cfg_ready, (i == 1));
      end
      if (i == 0) drive_cfg(1'b1, 0, 3);
      if (i == 1) drive_cfg(1'b0, 0, 0);
    end
  endtask

  task automatic test_high_extremes();
    int n;
    push_period(10, 5);
    push_period(10, 0);
    push_period(40, 50);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      got   = {period_start, wave, busy};
      exp_v = exp_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL high_extremes cyc %0d: got ps/wave/busy=%b want %b", i, got, exp_v);
      end
      if (i == 0)  drive_cfg(1'b1, 10, 0);
      if (i == 10) drive_cfg(1'b1, 40, 50);
      if (i == 1 || i == 11) drive_cfg(1'b0, 0, 0);
    end
  endtask

  task automatic test_stop_restart();
    int n;
    push_period(40, 50);
    push_period(40, 16);
    push_idle(4);
    push_period(40, 16);
    push_period(40, 16);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      got   = {period_start, wave, busy};
      exp_v = exp_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL stop_restart cyc %0d: got ps/wave/busy=%b want %b", i, got, exp_v);
      end
      if (i == 60 || i == 82 || i == 100 || i == 110) begin
        n_vec++;
        if (dbg_state !== ((i == 82) ? ST_IDLE : (i == 110) ? ST_RUN : ST_STOP)) begin
          n_err++;
          $display("FAIL stop_state cyc %0d: got %0d", i, dbg_state);
        end
      end
      if (i == 0)   drive_cfg(1'b1, 40, 16);
      if (i == 1)   drive_cfg(1'b0, 0, 0);
      if (i == 45)  en = 1'b0;
      if (i == 83)  en = 1'b1;
      if (i == 89)  en = 1'b0;
      if (i == 104) en = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    push_period(40, 16);
    for (int i = 0; i <= 30; i++) begin
      @(posedge clk);
      #1;
      got   = {period_start, wave, busy};
      exp_v = exp_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_pre cyc %0d: got ps/wave/busy=%b want %b", i, got, exp_v);
      end
      if (i == 26) begin
        n_vec++;
        if (cfg_ready !== 1'b0) begin
          n_err++;
          $display("FAIL reset_mid_pending: got ready %b want 0", cfg_ready);
        end
      end
      if (i == 25) drive_cfg(1'b1, 10, 5);
      if (i == 26) drive_cfg(1'b0, 0, 0);
    end
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({period_start, wave, busy, cfg_ready} !== 4'b0001 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_mid_async: got ps/wave/busy/ready=%b state=%0d want 0001/0",
               {period_start, wave, busy, cfg_ready}, dbg_state);
    end
    #2 rst_n = 1'b1;
    push_period(40, 16);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      got   = {period_start, wave, busy};
      exp_v = exp_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_post cyc %0d: got ps/wave/busy=%b want %b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_period_one();
    int n;
    push_period(40, 16);
    for (int k = 0; k < 8; k++) push_period(1, 0);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      got   = {period_start, wave, busy};
      exp_v = exp_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL period_one cyc %0d: got ps/wave/busy=%b want %b", i, got, exp_v);
      end
      if (i == 0) drive_cfg(1'b1, 1, 0);
      if (i == 1) drive_cfg(1'b0, 0, 0);
    end
  endtask

  task automatic test_idle_cfg();
    int n;
    en = 1'b0;
    push_idle(4);
    push_period(6, 2);
    push_period(6, 2);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      got   = {period_start, wave, busy};
      exp_v = exp_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL idle_cfg cyc %0d: got ps/wave/busy=%b want %b", i, got, exp_v);
      end
      if (i == 3 || i == 4) begin
        n_vec++;
        if (cfg_ready !== (i == 4)) begin
          n_err++;
          $display("FAIL idle_cfg_ready cyc %0d: got %b want %b", i, cfg_ready, (i == 4));
        end
      end
      if (i == 2) begin
        en = 1'b1;
        drive_cfg(1'b1, 6, 2);
      end
      if (i == 3) drive_cfg(1'b0, 0, 0);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_cfg_change();
    test_cfg_zero();
    test_high_extremes();
    test_stop_restart();
    test_reset_mid();
    test_period_one();
    test_idle_cfg();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
